// File: rtl/ps2_rx_decoder.sv
// PS/2 keyboard receiver: synchronises the raw PS/2 lines, frames 11-bit
// packets with start/parity/stop and inter-bit timeout checks, and folds
// E0/F0 prefixes into a single per-key event.
module ps2_rx_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err,
    output logic [7:0] scan_code,
    output logic       code_extended,
    output logic       code_release,
    output logic       code_valid
);

    localparam int unsigned SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic [SS-1:0] clk_sync;
    logic [SS-1:0] dat_sync;
    logic          clk_prev;
    logic          fall_q;
    logic          dat_q;

    state_t        state, state_nxt;
    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic [7:0]    shift, shift_nxt;
    logic          par_bit, par_nxt;
    logic [TW-1:0] to_cnt, to_cnt_nxt;
    logic [7:0]    byte_nxt;
    logic          valid_nxt;
    logic          err_nxt;

    logic          ext_pending;
    logic          rel_pending;

    // Synchronisers and falling-edge detect; the edge and the data sample are
    // registered together so the FSM sees them aligned.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
            fall_q   <= 1'b0;
            dat_q    <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SS-2:0], PS2_CLK};
            dat_sync <= {dat_sync[SS-2:0], PS2_DAT};
            clk_prev <= clk_sync[SS-1];
            fall_q   <= clk_prev & ~clk_sync[SS-1];
            dat_q    <= dat_sync[SS-1];
        end
    end

    // Framer state register and registered outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            par_bit   <= 1'b0;
            to_cnt    <= '0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shift     <= shift_nxt;
            par_bit   <= par_nxt;
            to_cnt    <= to_cnt_nxt;
            rx_byte   <= byte_nxt;
            rx_valid  <= valid_nxt;
            frame_err <= err_nxt;
        end
    end

    // Framer next-state: act only on a detected falling edge; otherwise run
    // the inter-bit timeout while a frame is in progress.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift;
        par_nxt     = par_bit;
        to_cnt_nxt  = to_cnt;
        byte_nxt    = rx_byte;
        valid_nxt   = 1'b0;
        err_nxt     = 1'b0;
        if (fall_q) begin
            to_cnt_nxt = '0;
            case (state)
                IDLE: begin
                    if (!dat_q) begin
                        state_nxt   = DATA;
                        bit_cnt_nxt = '0;
                    end
                end
                DATA: begin
                    shift_nxt = {dat_q, shift[7:1]};
                    if (bit_cnt == 3'd7) begin
                        state_nxt = PARITY;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                    end
                end
                PARITY: begin
                    par_nxt   = dat_q;
                    state_nxt = STOP;
                end
                STOP: begin
                    if (dat_q && ((^shift) ^ par_bit)) begin
                        byte_nxt  = shift;
                        valid_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end else if (state != IDLE) begin
            if (to_cnt == TO_LAST) begin
                err_nxt    = 1'b1;
                state_nxt  = IDLE;
                to_cnt_nxt = '0;
            end else begin
                to_cnt_nxt = to_cnt + TW'(1);
            end
        end else begin
            to_cnt_nxt = '0;
        end
    end

    // Prefix folding: E0/F0 only arm flags, any other byte emits an event;
    // a framing error or timeout drops any armed prefixes.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ext_pending   <= 1'b0;
            rel_pending   <= 1'b0;
            scan_code     <= '0;
            code_extended <= 1'b0;
            code_release  <= 1'b0;
            code_valid    <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            if (frame_err) begin
                ext_pending <= 1'b0;
                rel_pending <= 1'b0;
            end else if (rx_valid) begin
                if (rx_byte == 8'hE0) begin
                    ext_pending <= 1'b1;
                end else if (rx_byte == 8'hF0) begin
                    rel_pending <= 1'b1;
                end else begin
                    scan_code     <= rx_byte;
                    code_extended <= ext_pending;
                    code_release  <= rel_pending;
                    code_valid    <= 1'b1;
                    ext_pending   <= 1'b0;
                    rel_pending   <= 1'b0;
                end
            end
        end
    end

endmodule
